serial_addsub: RTL

Parametrised bit-serial adder/subtractor built around a single one-bit full-adder cell. It is the sequential successor of our one-bit full adder. It accepts two WIDTH-bit operands on a start pulse and resolves one bit per clock, LSB first. It then presents the sum, carry-out and signed overflow with a one-cycle done strobe. It sits in the lab datapath wherever area matters more than latency.

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_fa_cell.sv | 13 +
 rtl/serial_addsub.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder cell; the only arithmetic element of the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, with
// sum, carry-out and signed overflow registered on completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
        $error("serial_addsub: WIDTH out of legal range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_sum_s;
    logic             fa_carry_s;

    fa_cell u_fa (
        .a     (opa_q[0]),
        .b     (opb_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Next-state, datapath shift and result capture.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = {CNT_W{1'b0}};
                    res_d   = {WIDTH{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                res_d   = {fa_sum_s, res_q[WIDTH-1:1]};
                carry_d = fa_carry_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_carry_s;
                    ovf_d   = fa_carry_s ^ carry_q;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
